// File: rtl/argmax_fix11.sv
// Signed argmax over the inference engine's class scores.
// Walks out_idx 0..NUM_CLASSES-1, then holds the winning class and score with valid high.
module argmax_fix11 #(
    parameter int DATA_WIDTH  = 11,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [IDX_WIDTH-1:0]         out_idx,
    input  logic signed [DATA_WIDTH-1:0] out,
    output logic                         busy,
    output logic                         valid,
    output logic [IDX_WIDTH-1:0]         pred_class,
    output logic signed [DATA_WIDTH-1:0] pred_score
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                        state;
    state_t                        state_next;
    logic [IDX_WIDTH-1:0]          idx;
    logic [IDX_WIDTH-1:0]          best_idx;
    logic signed [DATA_WIDTH-1:0]  best_score;
    logic                          take;
    logic                          last;

    // Strict compare keeps the lowest index on ties; index 0 always seeds the best.
    assign take = (idx == '0) || (out > best_score);
    assign last = (idx == LAST_IDX);

    assign out_idx = idx;
    assign busy    = (state == SCAN);
    assign valid   = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last)  state_next = DONE;
            DONE:    if (start) state_next = SCAN;
            default: state_next = IDLE;
        endcase
    end

    // The final sample bypasses best_* so the result lands on the same edge as DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            best_idx   <= '0;
            best_score <= '0;
            pred_class <= '0;
            pred_score <= '0;
        end else if (state == SCAN) begin
            if (take) begin
                best_score <= out;
                best_idx   <= idx;
            end
            if (last) begin
                idx        <= '0;
                pred_class <= take ? idx : best_idx;
                pred_score <= take ? out : best_score;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            idx <= '0;
        end
    end

endmodule

// File: doc/argmax_fix11.md
# argmax_fix11

Classification stage that sits directly downstream of the fixed-point (11-bit) MNIST inference engine. After the engine signals completion, this block walks the engine's 10-entry output selector (`out_idx` / `out`), performs a signed argmax over the class scores, and presents the predicted digit and its winning score as registered outputs with a level `valid`.

## Interface
Parameters:
- DATA_WIDTH, 11, score width, signed two's complement
- NUM_CLASSES, 10, number of scores scanned (indices 0..NUM_CLASSES-1)
- IDX_WIDTH, 4, width of index / class outputs

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin a scan; sampled on rising edge; driven from engine `done`
- out_idx  out  IDX_WIDTH  score select driven to engine top
- out  in  DATA_WIDTH signed  selected score, combinational from engine top in the same cycle as `out_idx`
- busy  out  1  high while scanning
- valid  out  1  high when pred_class/pred_score hold a completed result
- pred_class  out  IDX_WIDTH  index of maximum score
- pred_score  out  DATA_WIDTH signed  maximum score value

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `out_idx`=0, `busy`=0. On `start`=1 → SCAN, idx counter=0.
- DONE: `valid`=1, outputs held. On `start`=1 → SCAN, idx=0, and `valid` drops on that same edge. `pred_class` and `pred_score` keep their old values until the new scan finishes.
- SCAN: `busy`=1, `out_idx`=idx counter. Each cycle `out` is sampled on the rising edge:
  - idx==0: best_score←out, best_idx←0 unconditionally.
  - idx>0: if `out` > best_score (signed, strict) then best_score←out, best_idx←idx.
  - idx increments by 1 each cycle.
  - On the cycle with idx==NUM_CLASSES-1, the final comparison result goes straight into `pred_class`/`pred_score`, `valid`←1, state→DONE, and idx returns to 0.
- Ties: the lowest index wins because the compare is strict. Equal scores never replace the current best.
- Arithmetic: comparison only; no widening or saturation. Full signed range −1024..+1023 is valid.
- `start` during SCAN is ignored; the scan is not restarted.
- `out_idx` never exceeds NUM_CLASSES-1.
- Reset (async, any state, including mid-scan):
  - state=IDLE, idx=0, `out_idx`=0.
  - `busy`=0, `valid`=0, `pred_class`=0, `pred_score`=0.
  - best_score=0, best_idx=0.
  - Release takes effect on the first rising edge with rst=1.

## Timing
- Edge E0: `start` sampled high in IDLE or DONE.
- Cycles after E0 through E10: `out_idx`=0..9, one per cycle, with `busy`=1.
- Edge E10 samples the score for idx 9.
- After E10: `valid`=1, `busy`=0, `pred_*` final.
- Result latency is NUM_CLASSES cycles from the `start` edge. Throughput is one classification per NUM_CLASSES+1 cycles when `start` is held high continuously (one DONE cycle between scans).
- `out` must settle combinationally within the same cycle `out_idx` is driven; there is no pipeline register on the score path.
- All outputs are registered; none depend combinationally on `out` or `start`.

## Test plan
- Distinct max:
  - Stimulus: scores {3,−5,12,7,0,1,−1,11,2,4}, pulse `start`.
  - Response: 10 cycles later `valid`=1, `pred_class`=2, `pred_score`=12, `busy` low.
- Ties and extremes:
  - Scores {5,9,9,−1024,9,0,0,0,0,0} → `pred_class`=1, `pred_score`=9.
  - All scores −1024 → `pred_class`=0, `pred_score`=−1024.
  - Max at last index (score 1023 at idx 9) → `pred_class`=9.
- Start while busy:
  - Stimulus: assert `start` again at scan cycle 4.
  - Response: `out_idx` continues 5..9 without restarting; result appears at the original time.
- Back-to-back:
  - Stimulus: hold `start`=1 continuously with different score sets.
  - Response: `valid` pulses high for 1 cycle every 11 cycles. `pred_*` update to each set's argmax and stay stable between results.
- Reset mid-scan:
  - Stimulus: drive rst=0 asynchronously (between edges) at `out_idx`=6.
  - Response: all outputs go to 0 immediately. After release, the block stays in IDLE with `valid`=0 until the next `start`, then a fresh scan returns the correct result.
- Reset in DONE:
  - Stimulus: rst=0 pulse while `valid`=1.
  - Response: `valid`, `pred_class` and `pred_score` all return to 0.
